// File: rtl/ddr5_sched_pkg.sv
// ----------------------------------------------------------------------------
// ddr5_sched_pkg
// Shared types for the DDR5 bank scheduler: command codes driven on cmd,
// scheduler FSM states and address-field offset helpers.
// Optional feature macro: REFRESH_EN (adds the refresh FSM states).
// ----------------------------------------------------------------------------
package ddr5_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_WAIT_CL,
        S_BURST
`ifdef REFRESH_EN
        ,
        S_PREA,
        S_WAIT_RPA,
        S_REF,
        S_WAIT_RFC
`endif
    } state_e;

    // Bank field sits directly above the column field.
    function automatic int unsigned bank_lsb(input int unsigned col_w);
        return col_w;
    endfunction

    // Row field sits directly above the bank field.
    function automatic int unsigned row_lsb(input int unsigned col_w,
                                            input int unsigned bank_w);
        return col_w + bank_w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr5_bank_table.sv
// ----------------------------------------------------------------------------
// ddr5_bank_table
// Per-bank open-row table for the open-page policy.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset (all closed)
//   i_lk_bank, i_lk_row     lookup key
//   o_open, o_hit           looked-up bank is open / open on i_lk_row
//   o_any_open              at least one bank open
//   i_open_en/_bank/_row    mark a bank open on a row
//   i_close_en/_bank        mark a bank closed
//   i_close_all             mark every bank closed
// ----------------------------------------------------------------------------
module ddr5_bank_table #(
    parameter int unsigned BANK_W = 2,
    parameter int unsigned ROW_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BANK_W-1:0] i_lk_bank,
    input  logic [ROW_W-1:0]  i_lk_row,
    output logic              o_open,
    output logic              o_hit,
    output logic              o_any_open,
    input  logic              i_open_en,
    input  logic [BANK_W-1:0] i_open_bank,
    input  logic [ROW_W-1:0]  i_open_row,
    input  logic              i_close_en,
    input  logic [BANK_W-1:0] i_close_bank,
    input  logic              i_close_all
);

    localparam int unsigned NUM_BANKS = 2 ** BANK_W;

    logic [NUM_BANKS-1:0] r_open;
    logic [ROW_W-1:0]     r_row [NUM_BANKS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_open <= '0;
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                r_row[i] <= '0;
            end
        end else if (i_close_all) begin
            r_open <= '0;
        end else begin
            if (i_close_en) begin
                r_open[i_close_bank] <= 1'b0;
            end
            if (i_open_en) begin
                r_open[i_open_bank] <= 1'b1;
                r_row[i_open_bank]  <= i_open_row;
            end
        end
    end

    assign o_open     = r_open[i_lk_bank];
    assign o_hit      = o_open && (r_row[i_lk_bank] == i_lk_row);
    assign o_any_open = |r_open;

endmodule

// File: rtl/ddr5_bank_sched.sv
// ----------------------------------------------------------------------------
// ddr5_bank_sched
// Read/write request scheduler with write-starvation protection and an
// open-page bank table. Issues PRE/ACT/RD/WR with tRP/tRCD/CL spacing and
// drives the SerDes data phase for BL beats. One request in flight.
// Optional feature macro: REFRESH_EN (periodic PREA/REF, T_REFI/T_RFC).
// Ports:
//   mem_clk, rst              clock, asynchronous active-high reset
//   rd_empty/rd_adrs/rd_pop   read-address FIFO head and pop pulse
//   wr_empty/wr_adrs/wr_pop   write-address FIFO head and pop pulse
//   cmd_valid, cmd            command strobe and code (cmd_e)
//   cmd_bank/cmd_row/cmd_col  command fields, held between commands
//   serdes_en, serdes_sel     data-phase enable, 0 = read / 1 = write
//   busy                      FSM not idle
// ----------------------------------------------------------------------------
module ddr5_bank_sched
    import ddr5_sched_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned ROW_W     = 16,
    parameter int unsigned T_RP      = 25,
    parameter int unsigned T_RCD     = 5,
    parameter int unsigned CL        = 20,
    parameter int unsigned BL        = 2,
    parameter int unsigned WR_STARVE = 4
`ifdef REFRESH_EN
    ,
    parameter int unsigned T_REFI    = 3900,
    parameter int unsigned T_RFC     = 295
`endif
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              rd_empty,
    input  logic [ADDR_W-1:0] rd_adrs,
    output logic              rd_pop,
    input  logic              wr_empty,
    input  logic [ADDR_W-1:0] wr_adrs,
    output logic              wr_pop,
    output logic              cmd_valid,
    output logic [2:0]        cmd,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              serdes_en,
    output logic              serdes_sel,
    output logic              busy
);

    localparam int unsigned BANK_LSB = bank_lsb(COL_W);
    localparam int unsigned ROW_LSB  = row_lsb(COL_W, BANK_W);
`ifdef REFRESH_EN
    localparam int unsigned MAX_D = max_u(max_u(max_u(T_RP, T_RCD), max_u(CL, BL)), T_RFC);
`else
    localparam int unsigned MAX_D = max_u(max_u(T_RP, T_RCD), max_u(CL, BL));
`endif
    localparam int unsigned CNT_W = $clog2(MAX_D);
    localparam int unsigned SW    = $clog2(WR_STARVE + 1);

    // The shared counter is loaded on entry to each issuing state, so the
    // wait state is left exactly <delay> cycles after the command cycle.
    localparam logic [CNT_W-1:0] L_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] L_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] L_CL  = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] L_BL  = CNT_W'(BL - 1);
    localparam logic [SW-1:0]    L_STV = SW'(WR_STARVE);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SW-1:0]     r_starve;
    logic              r_dir;
    logic [BANK_W-1:0] r_bank;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              r_cmd_valid;
    cmd_e              r_cmd;
    logic [BANK_W-1:0] r_cmd_bank;
    logic [ROW_W-1:0]  r_cmd_row;
    logic [COL_W-1:0]  r_cmd_col;
    logic              r_ser_en;
    logic              r_ser_sel;

    logic              w_req_ok;
    logic              w_grant_rd;
    logic              w_grant_wr;
    logic [ADDR_W-1:0] w_head;
    logic [BANK_W-1:0] w_head_bank;
    logic [ROW_W-1:0]  w_head_row;
    logic [COL_W-1:0]  w_head_col;
    logic              w_lk_open;
    logic              w_lk_hit;
    logic              w_any_open;
    logic              w_close_all;
    logic              w_unused;

`ifdef REFRESH_EN
    localparam int unsigned RW = $clog2(T_REFI);
    logic [RW-1:0] r_refi;
    logic          r_ref_pend;
    logic          w_ref_done;

    assign w_ref_done  = (r_state == S_WAIT_RFC) && (r_cnt == '0);
    assign w_close_all = (r_state == S_PREA);
    assign w_req_ok    = (r_state == S_IDLE) && !r_ref_pend;
    assign w_unused    = ^w_head[ADDR_W-1:ROW_LSB+ROW_W];

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            r_refi     <= '0;
            r_ref_pend <= 1'b0;
        end else begin
            if (w_ref_done) begin
                r_ref_pend <= 1'b0;
            end
            if (r_refi == RW'(T_REFI - 1)) begin
                r_refi     <= '0;
                r_ref_pend <= 1'b1;
            end else begin
                r_refi <= r_refi + 1'b1;
            end
        end
    end
`else
    assign w_close_all = 1'b0;
    assign w_req_ok    = (r_state == S_IDLE);
    assign w_unused    = ^{w_head[ADDR_W-1:ROW_LSB+ROW_W], w_any_open};
`endif

    // Read wins unless the waiting write has been passed over WR_STARVE times.
    assign w_grant_rd  = w_req_ok && !rd_empty && (wr_empty || (r_starve != L_STV));
    assign w_grant_wr  = w_req_ok && !wr_empty && !w_grant_rd;
    assign rd_pop      = w_grant_rd && !rst;
    assign wr_pop      = w_grant_wr && !rst;

    assign w_head      = w_grant_wr ? wr_adrs : rd_adrs;
    assign w_head_bank = w_head[BANK_LSB +: BANK_W];
    assign w_head_row  = w_head[ROW_LSB +: ROW_W];
    assign w_head_col  = w_head[COL_W-1:0];

    ddr5_bank_table #(
        .BANK_W (BANK_W),
        .ROW_W  (ROW_W)
    ) u_bank_table (
        .i_clk        (mem_clk),
        .i_rst        (rst),
        .i_lk_bank    (w_head_bank),
        .i_lk_row     (w_head_row),
        .o_open       (w_lk_open),
        .o_hit        (w_lk_hit),
        .o_any_open   (w_any_open),
        .i_open_en    (r_state == S_ACT),
        .i_open_bank  (r_bank),
        .i_open_row   (r_row),
        .i_close_en   (r_state == S_PRE),
        .i_close_bank (r_bank),
        .i_close_all  (w_close_all)
    );

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_dir       <= 1'b0;
            r_bank      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_NOP;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_ser_en    <= 1'b0;
            r_ser_sel   <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_NOP;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            case (r_state)
                S_IDLE: begin
`ifdef REFRESH_EN
                    if (r_ref_pend) begin
                        r_cmd_valid <= 1'b1;
                        if (w_any_open) begin
                            r_cmd   <= CMD_PREA;
                            r_cnt   <= L_RP;
                            r_state <= S_PREA;
                        end else begin
                            r_cmd   <= CMD_REF;
                            r_cnt   <= CNT_W'(T_RFC - 1);
                            r_state <= S_REF;
                        end
                    end else if (w_grant_rd || w_grant_wr) begin
`else
                    if (w_grant_rd || w_grant_wr) begin
`endif
                        r_dir       <= w_grant_wr;
                        r_bank      <= w_head_bank;
                        r_row       <= w_head_row;
                        r_col       <= w_head_col;
                        r_cmd_valid <= 1'b1;
                        r_cmd_bank  <= w_head_bank;
                        if (w_grant_wr) begin
                            r_starve <= '0;
                        end else if (!wr_empty && (r_starve != L_STV)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                        if (w_lk_hit) begin
                            r_cmd     <= w_grant_wr ? CMD_WR : CMD_RD;
                            r_cmd_col <= w_head_col;
                            r_cnt     <= L_CL;
                            r_state   <= S_CAS;
                        end else if (w_lk_open) begin
                            r_cmd   <= CMD_PRE;
                            r_cnt   <= L_RP;
                            r_state <= S_PRE;
                        end else begin
                            r_cmd     <= CMD_ACT;
                            r_cmd_row <= w_head_row;
                            r_cnt     <= L_RCD;
                            r_state   <= S_ACT;
                        end
                    end
                end
                S_PRE:      r_state <= S_WAIT_RP;
                S_WAIT_RP: begin
                    if (r_cnt == '0) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_ACT;
                        r_cmd_bank  <= r_bank;
                        r_cmd_row   <= r_row;
                        r_cnt       <= L_RCD;
                        r_state     <= S_ACT;
                    end
                end
                S_ACT:      r_state <= S_WAIT_RCD;
                S_WAIT_RCD: begin
                    if (r_cnt == '0) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= r_dir ? CMD_WR : CMD_RD;
                        r_cmd_bank  <= r_bank;
                        r_cmd_col   <= r_col;
                        r_cnt       <= L_CL;
                        r_state     <= S_CAS;
                    end
                end
                S_CAS:      r_state <= S_WAIT_CL;
                S_WAIT_CL: begin
                    if (r_cnt == '0) begin
                        r_ser_en  <= 1'b1;
                        r_ser_sel <= r_dir;
                        r_cnt     <= L_BL;
                        r_state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (r_cnt == '0) begin
                        r_ser_en  <= 1'b0;
                        r_ser_sel <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
`ifdef REFRESH_EN
                S_PREA:     r_state <= S_WAIT_RPA;
                S_WAIT_RPA: begin
                    if (r_cnt == '0) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_REF;
                        r_cnt       <= CNT_W'(T_RFC - 1);
                        r_state     <= S_REF;
                    end
                end
                S_REF:      r_state <= S_WAIT_RFC;
                S_WAIT_RFC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd        = r_cmd;
    assign cmd_bank   = r_cmd_bank;
    assign cmd_row    = r_cmd_row;
    assign cmd_col    = r_cmd_col;
    assign serdes_en  = r_ser_en;
    assign serdes_sel = r_ser_sel;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ddr5_bank_sched.sv
// ----------------------------------------------------------------------------
// tb_ddr5_bank_sched
// Self-checking bench for ddr5_bank_sched. A timeline model predicts, per
// cycle, pops, commands, busy and the SerDes burst from the scheduling rules
// (arbitration, open-page table, tRP/tRCD/CL/BL spacing).
// ----------------------------------------------------------------------------
module tb_ddr5_bank_sched;

    localparam int unsigned T_RP      = 3;
    localparam int unsigned T_RCD     = 2;
    localparam int unsigned CL        = 4;
    localparam int unsigned BL        = 2;
    localparam int unsigned WR_STARVE = 2;
    localparam int          N         = 8192;

    localparam bit [2:0] C_ACT = 3'd1;
    localparam bit [2:0] C_RD  = 3'd2;
    localparam bit [2:0] C_WR  = 3'd3;
    localparam bit [2:0] C_PRE = 3'd4;

    logic        mem_clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_empty = 1'b1;
    logic [31:0] rd_adrs = '0;
    logic        wr_empty = 1'b1;
    logic [31:0] wr_adrs = '0;
    logic        rd_pop, wr_pop, cmd_valid, serdes_en, serdes_sel, busy;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;

    ddr5_bank_sched #(
        .T_RP      (T_RP),
        .T_RCD     (T_RCD),
        .CL        (CL),
        .BL        (BL),
        .WR_STARVE (WR_STARVE)
    ) dut (
        .mem_clk    (mem_clk),
        .rst        (rst),
        .rd_empty   (rd_empty),
        .rd_adrs    (rd_adrs),
        .rd_pop     (rd_pop),
        .wr_empty   (wr_empty),
        .wr_adrs    (wr_adrs),
        .wr_pop     (wr_pop),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .serdes_en  (serdes_en),
        .serdes_sel (serdes_sel),
        .busy       (busy)
    );

    always #5 mem_clk = ~mem_clk;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          free_at = 0;
    int          starve_m = 0;
    int          last_c = -100;
    bit          open_m [4];
    bit [15:0]   row_m [4];
    logic [31:0] rdq [$];
    logic [31:0] wrq [$];
    bit [31:0]   ord_bits;
    int          ord_n;

    bit          e_rdpop [N];
    bit          e_wrpop [N];
    bit          e_cv    [N];
    bit          e_en    [N];
    bit          e_sel   [N];
    bit          e_busy  [N];
    bit [2:0]    e_cmd   [N];
    bit [1:0]    e_bank  [N];
    bit [15:0]   e_arg   [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        rd_empty = (rdq.size() == 0);
        wr_empty = (wrq.size() == 0);
        rd_adrs  = '0;
        wr_adrs  = '0;
        if (!rd_empty) rd_adrs = rdq[0];
        if (!wr_empty) wr_adrs = wrq[0];
    endtask

    task automatic put_cmd(input int k, input bit [2:0] c, input bit [1:0] b, input bit [15:0] arg);
        if (k < N) begin
            e_cv[k]   = 1'b1;
            e_cmd[k]  = c;
            e_bank[k] = b;
            e_arg[k]  = arg;
        end
    endtask

    // Timeline model: on a grant, lay out every future cycle of the request.
    task automatic model_eval();
        bit          g_rd, g_wr;
        logic [31:0] a;
        bit [1:0]    b;
        bit [15:0]   r;
        int          n, c;
        if (cyc < free_at) return;
        g_rd = (rdq.size() > 0) && ((wrq.size() == 0) || (starve_m != WR_STARVE));
        g_wr = !g_rd && (wrq.size() > 0);
        if (!g_rd && !g_wr) return;
        a = g_wr ? wrq[0] : rdq[0];
        b = a[11:10];
        r = a[27:12];
        e_rdpop[cyc] = g_rd;
        e_wrpop[cyc] = g_wr;
        n = cyc + 1;
        if (open_m[b] && row_m[b] == r) begin
            c = n;
        end else begin
            if (open_m[b]) begin
                put_cmd(n, C_PRE, b, 16'd0);
                n += T_RP;
            end
            put_cmd(n, C_ACT, b, r);
            c = n + T_RCD;
            open_m[b] = 1'b1;
            row_m[b]  = r;
        end
        put_cmd(c, g_wr ? C_WR : C_RD, b, {6'd0, a[9:0]});
        for (int k = cyc + 1; k < c + CL + BL && k < N; k++) e_busy[k] = 1'b1;
        for (int k = c + CL; k < c + CL + BL && k < N; k++) begin
            e_en[k]  = 1'b1;
            e_sel[k] = g_wr;
        end
        free_at = c + CL + BL;
        last_c  = c;
        if (g_wr) starve_m = 0;
        else if (wrq.size() > 0 && starve_m < WR_STARVE) starve_m++;
    endtask

    task automatic step();
        bit p_rd, p_wr;
        @(negedge mem_clk);
        model_eval();
        if (cyc < N) begin
            check_eq("rd_pop", rd_pop, e_rdpop[cyc]);
            check_eq("wr_pop", wr_pop, e_wrpop[cyc]);
            check_eq("busy", busy, e_busy[cyc]);
            check_eq("serdes_en", serdes_en, e_en[cyc]);
            if (e_en[cyc]) check_eq("serdes_sel", serdes_sel, e_sel[cyc]);
            check_eq("cmd_valid", cmd_valid, e_cv[cyc]);
            if (e_cv[cyc]) begin
                check_eq("cmd", cmd, e_cmd[cyc]);
                check_eq("cmd_bank", cmd_bank, e_bank[cyc]);
                if (e_cmd[cyc] == C_ACT) check_eq("cmd_row", cmd_row, e_arg[cyc]);
                if (e_cmd[cyc] == C_RD || e_cmd[cyc] == C_WR) check_eq("cmd_col", cmd_col, e_arg[cyc]);
            end
        end
        p_rd = rd_pop;
        p_wr = wr_pop;
        if (p_rd || p_wr) begin
            ord_bits = {ord_bits[30:0], p_wr};
            ord_n++;
        end
        @(posedge mem_clk);
        if (p_rd && rdq.size() > 0) void'(rdq.pop_front());
        if (p_wr && wrq.size() > 0) void'(wrq.pop_front());
        #1;
        cyc++;
        drive();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((rdq.size() != 0 || wrq.size() != 0 || cyc < free_at) && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("drain_done", (n < max_cyc), 1);
        step();
    endtask

    task automatic check_all_zero();
        check_eq("rst_rd_pop", rd_pop, 0);
        check_eq("rst_wr_pop", wr_pop, 0);
        check_eq("rst_cmd_valid", cmd_valid, 0);
        check_eq("rst_cmd", cmd, 0);
        check_eq("rst_cmd_bank", cmd_bank, 0);
        check_eq("rst_cmd_row", cmd_row, 0);
        check_eq("rst_cmd_col", cmd_col, 0);
        check_eq("rst_serdes_en", serdes_en, 0);
        check_eq("rst_serdes_sel", serdes_sel, 0);
        check_eq("rst_busy", busy, 0);
    endtask

    // Assert reset (optionally checking outputs 1 time unit later), hold it,
    // release, and restart the model with an empty bank table.
    task automatic reset_seq(input bit immediate);
        rst = 1'b1;
        #1;
        if (immediate) check_all_zero();
        repeat (2) @(posedge mem_clk);
        #1;
        check_all_zero();
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            e_rdpop[k] = 0; e_wrpop[k] = 0; e_cv[k] = 0;
            e_en[k] = 0; e_sel[k] = 0; e_busy[k] = 0;
        end
        for (int b = 0; b < 4; b++) open_m[b] = 1'b0;
        starve_m = 0;
        rdq.delete();
        wrq.delete();
        drive();
        cyc = 0;
        free_at = 0;
    endtask

    function automatic logic [31:0] rand_adrs();
        logic [15:0] r;
        logic [1:0]  b;
        logic [9:0]  c;
        r = 16'($urandom_range(0, 2));
        b = 2'($urandom_range(0, 3));
        c = 10'($urandom_range(0, 1023));
        return {4'h0, r, b, c};
    endfunction

    initial begin
        int n;
        drive();
        reset_seq(1'b0);

        // cold read, row hit, row conflict on bank 1
        rdq.push_back(32'h0000_1405); drive(); drain(100);
        rdq.push_back(32'h0000_1406); drive(); drain(100);
        rdq.push_back(32'h0000_2405); drive(); drain(100);

        // five reads and one write pending together
        ord_bits = '0;
        ord_n    = 0;
        for (int i = 0; i < 5; i++) rdq.push_back({4'h0, 16'h0005, 2'd2, 10'(i)});
        wrq.push_back(32'h0000_7c00);
        drive();
        drain(400);
        check_eq("grant_count", ord_n, 6);
        check_eq("grant_order", {26'd0, ord_bits[5:0]}, 32'b001000);

        // write to address 0
        wrq.push_back(32'h0000_0000); drive(); drain(100);

        // reset in the middle of WAIT_CL, with a write waiting
        last_c = -100;
        rdq.push_back(32'h0000_3000); drive();
        n = 0;
        while (cyc != last_c + 2 && n < 60) begin
            step();
            n++;
        end
        check_eq("reach_wait_cl", (cyc == last_c + 2), 1);
        wrq.push_back(32'h0000_0400); drive();
        reset_seq(1'b1);
        rdq.push_back(32'h0000_3000); drive(); drain(100);

        // random traffic across a few rows per bank
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) rdq.push_back(rand_adrs());
            if ($urandom_range(0, 9) == 0) wrq.push_back(rand_adrs());
            drive();
            step();
        end
        drain(5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1);
    end

endmodule
